// File: rtl/bus_arbiter_pkg.sv
// Shared CPU package: arbiter FSM states, default sizing constants and a
// modulo-N increment helper used for the round-robin pointer.
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEFAULT_N_REQ    = 4;
    localparam int DEFAULT_MAX_HOLD = 8;

    // Next index after v, wrapping at n rather than at a power of two.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of req at ptr, ptr+1, ...
// wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    localparam int P  = 2 ** W;
    localparam int SW = W + 1;

    logic [P-1:0] req_pad;
    logic [W-1:0] cand [N];
    logic [N-1:0] hit;

    // Padding to a power of two lets the candidate index select without width games.
    assign req_pad = P'(req);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [W:0] sum;
            assign sum      = {1'b0, ptr} + SW'(gi);
            assign cand[gi] = (sum >= SW'(N)) ? W'(sum - SW'(N)) : sum[W-1:0];
            assign hit[gi]  = req_pad[cand[gi]];
        end
    endgenerate

    // Walk offsets from far to near so the smallest offset from ptr wins.
    always_comb begin
        found = |hit;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with bounded locked grants; registered outputs,
// one-cycle grant latency, timeout pulse when a lock is forcibly broken.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_REQ    = DEFAULT_N_REQ,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic                     i_lock,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_gntId,
    output logic                     o_valid,
    output logic                     o_timeout
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD);

    arb_state_t     state_reg, state_next;
    logic [IW-1:0]  ptr_reg, ptr_next;
    logic [HW-1:0]  hold_reg, hold_next;
    logic [IW-1:0]  owner_reg, owner_next;
    logic           valid_reg, valid_next;
    logic           timeout_reg, timeout_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;

    logic [IW-1:0]  owner_inc;
    logic [IW-1:0]  pick_ptr;
    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic           owner_req;
    logic           keep;

    assign owner_inc = IW'(wrap_inc(int'(owner_reg), N_REQ));
    assign owner_req = i_req[owner_reg];
    assign keep      = (state_reg == GRANT) && i_lock && owner_req
                       && (hold_reg < HW'(MAX_HOLD - 1));
    // On release the search already starts past the outgoing owner.
    assign pick_ptr  = (state_reg == GRANT) ? owner_inc : ptr_reg;

    rr_pick #(
        .N(N_REQ),
        .W(IW)
    ) u_rr_pick (
        .req   (i_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        hold_next    = hold_reg;
        owner_next   = owner_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;
        gnt_next     = '0;

        case (state_reg)
            IDLE: begin
                hold_next = '0;
                if (pick_found) begin
                    state_next = GRANT;
                    owner_next = pick_idx;
                    valid_next = 1'b1;
                end else begin
                    owner_next = '0;
                    valid_next = 1'b0;
                end
            end
            GRANT: begin
                if (keep) begin
                    hold_next = hold_reg + HW'(1);
                end else begin
                    ptr_next     = owner_inc;
                    hold_next    = '0;
                    // Lock still wanted and owner still requesting: only the hold limit released it.
                    timeout_next = i_lock && owner_req;
                    if (pick_found) begin
                        owner_next = pick_idx;
                        valid_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                        owner_next = '0;
                        valid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                owner_next = '0;
                valid_next = 1'b0;
            end
        endcase

        if (valid_next) begin
            gnt_next = N_REQ'(1) << owner_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            hold_reg    <= '0;
            owner_reg   <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            gnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
            owner_reg   <= owner_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
            gnt_reg     <= gnt_next;
        end
    end

    assign o_gnt     = gnt_reg;
    assign o_gntId   = owner_reg;
    assign o_valid   = valid_reg;
    assign o_timeout = timeout_reg;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, meaning the number of bus drivers (ALU, regset, RAM, PC and so on), legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 8, meaning the maximum consecutive cycles of one locked grant, legal range 2..255.
REQ-003 i_clk  input  1  meaning the single clock; all state SHALL change on its rising edge only.
REQ-004 i_reset  input  1  meaning the reset, which SHALL be synchronous and active-low.
REQ-005 i_req  input  N_REQ  meaning the per-driver bus request, level-sensitive.
REQ-006 i_lock  input  1  meaning the current owner requests to keep the bus for another cycle.
REQ-007 o_gnt  output  N_REQ  meaning the one-hot bus output enable, zero or one bit set.
REQ-008 o_gntId  output  clog2(N_REQ)  meaning the index of the owner, 0 when o_valid=0.
REQ-009 o_valid  output  1  meaning some driver owns the bus this cycle.
REQ-010 o_timeout  output  1  meaning a one-cycle pulse when a locked grant is forcibly revoked.

Function
- REQ-011 The block SHALL use two states: IDLE (no owner) and GRANT (one owner).
- REQ-012 All outputs SHALL be registered; the grant appears in the cycle after the request is sampled (latency 1).
- REQ-013 Round-robin pointer ptr:
  - in IDLE with any i_req set, select the first set bit at index ptr, ptr+1, ... wrapping modulo N_REQ;
  - set o_gnt, o_gntId and o_valid; enter GRANT; clear holdCnt to 0.
- REQ-014 IDLE with i_req all zero SHALL remain in IDLE with o_gnt=0 and o_valid=0.
- REQ-015 GRANT SHALL retain the owner when i_lock=1, i_req[owner]=1 and holdCnt<MAX_HOLD-1; in that case holdCnt SHALL increment.
- REQ-016 Otherwise GRANT SHALL release the owner; release triggers are:
  - the lock is absent;
  - the owner has dropped its request;
  - holdCnt has reached MAX_HOLD-1.
- REQ-017 On release, ptr SHALL become (owner+1) mod N_REQ.
- REQ-018 On release, the next owner SHALL be chosen in the same cycle from i_req using the new ptr.
  - If a requester exists, the next owner receives the grant on the next edge with no idle cycle and holdCnt clears.
  - If no requester exists, the state returns to IDLE.
- REQ-019 Unlocked grants SHALL last exactly one cycle, so a driver holding i_req continuously receives every N_REQ-th cycle under full load.
- REQ-020 A release forced by holdCnt=MAX_HOLD-1 while i_lock=1 and i_req[owner]=1 SHALL assert o_timeout for exactly the following cycle. No other release SHALL assert it.
- REQ-021 The released owner is eligible again only after all other requesters, ensuring no starvation.
- REQ-022 o_gnt SHALL never have more than one bit set, including across reset and owner hand-over.
- REQ-023 Request bits at indices ≥ N_REQ do not exist; ptr and owner arithmetic SHALL wrap modulo N_REQ, not modulo 2^width.

Reset
- REQ-024 When i_reset=0 at a rising edge, the following SHALL take effect on that edge:
  - state=IDLE, ptr=0, holdCnt=0;
  - o_gnt=0, o_gntId=0, o_valid=0, o_timeout=0.
- REQ-025 Reset during GRANT SHALL drop the grant at that edge regardless of i_lock.
- REQ-026 The first arbitration after reset deassertion SHALL start from ptr=0.

Structure
- REQ-027 State enum (IDLE, GRANT) and the default N_REQ and MAX_HOLD constants SHALL live in the shared CPU package.
- REQ-028 The round-robin first-set-bit search from ptr SHALL be a combinational sub-module rr_pick, with inputs req and ptr and outputs found and idx.
- REQ-029 bus_arbiter SHALL contain only the FSM, ptr, holdCnt and the output registers.

Verification
- REQ-030 Reset sequence: i_req=4'b1111 while i_reset=0, then i_reset=1 -> next cycle o_gnt=0001, then 0010, 0100, 1000, 0001 on consecutive cycles; o_valid stays 1 throughout.
- REQ-031 Locked grant: i_req=4'b0100 with i_lock=1 held -> o_gnt=0100 for 8 cycles, then o_timeout=1 for one cycle together with o_gnt=0100 re-granted. ptr has wrapped past the other idle drivers, so the same owner wins again.
- REQ-032 Lock with competition: i_req=4'b0011, i_lock=1 for 3 cycles then 0 -> o_gnt=0001 for 4 cycles, then 0010 with no gap; o_timeout never asserts.
- REQ-033 Owner drop: grant 0010 locked, driver 1 drops i_req while i_req[3]=1 -> next cycle o_gnt=1000.
- REQ-034 Mid-grant reset: i_reset=0 for one edge during a locked grant -> o_gnt=0 and o_valid=0 that edge. After release, i_req=4'b1000 -> grant 1000 one cycle later.
- REQ-035 A one-hot/zero assertion on o_gnt and an o_gntId-consistency assertion SHALL be active in every scenario, including a randomized i_req/i_lock soak.
